// File: rtl/tx_interface.sv
// -----------------------------------------------------------------------------
// tx_interface
//
// Response-side framer for the UART ALU link. It latches the 8-bit ALU result
// on a write strobe and converts it to three ASCII decimal digits with leading
// zeros ("000".."255"). It then hands the characters one at a time to the
// UART transmitter using a start / done-tick handshake.
//
// Configuration macro:
//   TX_IF_NEWLINE_EN - when defined, a fourth character (LF, 8'h0A) is sent
//                      after the units digit. When undefined, exactly three
//                      characters are sent.
//
// Parameters:
//   DBIT          width of the result and of the UART data byte (only 8)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   wr            one-cycle request strobe: latch result, start a response
//   result        unsigned ALU result, sampled when wr=1 in IDLE
//   tx_done_tick  transmitter finished shifting out the current character
//   tx_start      one-cycle request to the transmitter to send din
//   din           ASCII character for the transmitter (registered)
//   busy          high whenever a response is being built or sent
//   done_tick     one-cycle pulse after the last character has gone out
//
// Notes:
//   The binary-to-decimal conversion uses repeated subtraction: one cycle per
//   hundred, one cycle per ten, plus one exit cycle for each digit. A
//   divider is not needed at this rate.
//
//   tx_start and done_tick are registered on the edge that leaves LOAD or
//   WAIT. din is loaded on that same edge, so the transmitter always sees a
//   stable character while tx_start is high. done_tick is high during the
//   first IDLE cycle, which is why busy is already low while it pulses.
// -----------------------------------------------------------------------------
module tx_interface #(
  parameter int DBIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] result,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [7:0]      din,
  output logic            busy,
  output logic            done_tick
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_H = 3'd1,
    CONV_T = 3'd2,
    LOAD   = 3'd3,
    WAIT   = 3'd4
  } state_t;

  // Index of the final character of a response.
`ifdef TX_IF_NEWLINE_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  state_t     state_reg, state_next;
  logic [7:0] rem_reg, rem_next;
  logic [3:0] hund_reg, hund_next;
  logic [3:0] tens_reg, tens_next;
  logic [1:0] idx_reg, idx_next;
  logic [7:0] din_reg, din_next;
  logic       tx_start_reg, tx_start_next;
  logic       done_reg, done_next;
  logic [7:0] char_sel;

  // ---------------------------------------------------------------------------
  // State register (async active-low reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rem_reg      <= 8'd0;
      hund_reg     <= 4'd0;
      tens_reg     <= 4'd0;
      idx_reg      <= 2'd0;
      din_reg      <= 8'h00;
      tx_start_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rem_reg      <= rem_next;
      hund_reg     <= hund_next;
      tens_reg     <= tens_next;
      idx_reg      <= idx_next;
      din_reg      <= din_next;
      tx_start_reg <= tx_start_next;
      done_reg     <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    hund_next  = hund_reg;
    tens_next  = tens_reg;
    idx_next   = idx_reg;

    case (state_reg)
      IDLE: begin
        // wr is only honoured here; requests in any other state are dropped.
        if (wr) begin
          rem_next   = result;
          hund_next  = 4'd0;
          tens_next  = 4'd0;
          state_next = CONV_H;
        end
      end

      CONV_H: begin
        // The compare guarantees the subtraction never borrows.
        if (rem_reg >= 8'd100) begin
          rem_next  = rem_reg - 8'd100;
          hund_next = hund_reg + 4'd1;
        end else begin
          state_next = CONV_T;
        end
      end

      CONV_T: begin
        if (rem_reg >= 8'd10) begin
          rem_next  = rem_reg - 8'd10;
          tens_next = tens_reg + 4'd1;
        end else begin
          // rem now holds the units digit and stays put until the next request.
          idx_next   = 2'd0;
          state_next = LOAD;
        end
      end

      LOAD: begin
        state_next = WAIT;
      end

      WAIT: begin
        if (tx_done_tick) begin
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = LOAD;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // Character selected by the current index.
  always_comb begin
    char_sel = ASCII_ZERO;
    case (idx_reg)
      2'd0: char_sel = ASCII_ZERO + {4'h0, hund_reg};
      2'd1: char_sel = ASCII_ZERO + {4'h0, tens_reg};
      2'd2: char_sel = ASCII_ZERO + {4'h0, rem_reg[3:0]};
`ifdef TX_IF_NEWLINE_EN
      2'd3: char_sel = ASCII_LF;
`else
      // Index 3 is never reached without the trailing newline.
      2'd3: char_sel = ASCII_ZERO;
`endif
      default: char_sel = ASCII_ZERO;
    endcase
  end

  always_comb begin
    // din keeps the last character sent until the next LOAD.
    din_next      = din_reg;
    tx_start_next = 1'b0;
    done_next     = 1'b0;

    if (state_reg == LOAD) begin
      din_next      = char_sel;
      tx_start_next = 1'b1;
    end

    if ((state_reg == WAIT) && tx_done_tick && (idx_reg == LAST_IDX)) begin
      done_next = 1'b1;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign tx_start  = tx_start_reg;
  assign din       = din_reg;
  assign done_tick = done_reg;

endmodule
